// File: rtl/ifetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory req/ack channel, decode valid/ready slot,
// redirect input and the architectural fetch PC.
interface ifetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic [31:0] pc;

    modport master (
        output imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc4, pc,
        input  imem_ack, imem_rdata, redirect, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc4, pc,
        output imem_ack, imem_rdata, redirect, redirect_pc, id_ready
    );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues one word read at a time and
// holds the fetched instruction for decode; redirects squash stale or held data.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic           clk,
    input logic           rst,
    ifetch_unit_if.master bus
);

    typedef enum logic [1:0] {StIdle, StReq, StWaitId, StDrop} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc4_q, id_pc4_d;
    logic        req_q, req_d;
    logic        valid_q, valid_d;
    logic [31:0] target;

    assign target = bus.redirect_pc & ~32'h3;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        addr_d   = addr_q;
        instr_d  = instr_q;
        id_pc_d  = id_pc_q;
        id_pc4_d = id_pc4_q;
        req_d    = req_q;
        valid_d  = valid_q;

        unique case (state_q)
            StIdle: begin
                pc_d    = bus.redirect ? target : pc_q;
                addr_d  = bus.redirect ? target : pc_q;
                req_d   = 1'b1;
                state_d = StReq;
            end
            StReq: begin
                if (bus.redirect) begin
                    pc_d    = target;
                    valid_d = 1'b0;
                    if (bus.imem_ack) begin
                        // Returned word belongs to the old stream; reissue at the target.
                        addr_d = target;
                    end else begin
                        state_d = StDrop;
                    end
                end else if (bus.imem_ack) begin
                    instr_d  = bus.imem_rdata;
                    id_pc_d  = addr_q;
                    id_pc4_d = addr_q + 32'd4;
                    valid_d  = 1'b1;
                    pc_d     = pc_q + 32'd4;
                    req_d    = 1'b0;
                    state_d  = StWaitId;
                end
            end
            StWaitId: begin
                if (bus.redirect) begin
                    pc_d    = target;
                    valid_d = 1'b0;
                    addr_d  = target;
                    req_d   = 1'b1;
                    state_d = StReq;
                end else if (bus.id_ready) begin
                    valid_d = 1'b0;
                    addr_d  = pc_q;
                    req_d   = 1'b1;
                    state_d = StReq;
                end
            end
            StDrop: begin
                // Old request must still complete before the new address may be driven.
                if (bus.redirect) begin
                    pc_d = target;
                end
                if (bus.imem_ack) begin
                    addr_d  = bus.redirect ? target : pc_q;
                    state_d = StReq;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            pc_q     <= RESET_PC;
            addr_q   <= RESET_PC;
            instr_q  <= 32'h0;
            id_pc_q  <= 32'h0;
            id_pc4_q <= 32'h0;
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            instr_q  <= instr_d;
            id_pc_q  <= id_pc_d;
            id_pc4_q <= id_pc4_d;
            req_q    <= req_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.imem_req  = req_q;
    assign bus.imem_addr = addr_q;
    assign bus.id_valid  = valid_q;
    assign bus.id_instr  = instr_q;
    assign bus.id_pc     = id_pc_q;
    assign bus.id_pc4    = id_pc4_q;
    assign bus.pc        = pc_q;

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction-fetch front end of the MIPS core: the producer side of the program counter.
- Owns the fetch PC and issues word reads to instruction memory over a req/ack handshake.
- Presents each fetched instruction, its PC and PC+4 to decode over a valid/ready handshake.
- Applies branch/jump redirects, discarding any stale in-flight or held instruction.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset (bits [1:0] must be 0).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- imem_req  output  1  read request to instruction memory
- imem_addr  output  32  word-aligned read address, valid while imem_req=1
- imem_ack  input  1  memory response strobe; imem_rdata valid this cycle
- imem_rdata  input  32  instruction word returned
- redirect  input  1  one-cycle pulse: change fetch stream
- redirect_pc  input  32  new fetch target
- id_valid  output  1  instruction slot to decode is full
- id_ready  input  1  decode accepts the slot this cycle
- id_instr  output  32  held instruction
- id_pc  output  32  address of id_instr
- id_pc4  output  32  id_pc+4
- pc  output  32  current fetch PC (next address to be requested)

Behaviour:
- One clock (clk); reset rst is synchronous and active-high. All outputs are registered.
- Reset values: pc=RESET_PC, imem_addr=RESET_PC, imem_req=0, id_valid=0, id_instr=0, id_pc=0, id_pc4=0, state=IDLE. Reset overrides every other input, including mid-request; a pending memory ack after reset is ignored.
- States:
  - IDLE: next cycle goes to REQ with imem_req<=1, imem_addr<=pc. Ack is ignored in IDLE.
  - REQ: imem_req=1, imem_addr held stable until imem_ack. On ack with no redirect:
    - id_instr<=imem_rdata, id_pc<=imem_addr, id_pc4<=imem_addr+4, id_valid<=1
    - pc<=pc+4, imem_req<=0, go to WAIT_ID.
  - WAIT_ID: id_valid=1, outputs stable. On id_ready: id_valid<=0, imem_req<=1, imem_addr<=pc, go to REQ. Minimum fetch period is 2 cycles (REQ with 0-wait ack, then WAIT_ID with ready).
  - DROP: a request is still outstanding but its data is stale. imem_req stays 1 with the old imem_addr. On ack: data discarded, imem_addr<=pc, go to REQ (imem_req stays 1).
- Memory handshake rule: once imem_req is asserted, imem_addr must not change and imem_req must not drop until the cycle after imem_ack. Exactly one request is outstanding at a time.
- Redirect has priority over the normal flow in every state except reset:
  - pc<=redirect_pc with bits [1:0] forced to 00, and id_valid<=0.
  - In REQ without ack: go to DROP.
  - In REQ with ack in the same cycle: rdata is discarded, imem_addr<=new pc, stay in REQ.
  - In WAIT_ID, including when id_ready=1 the same cycle: the held instruction is dropped. Go to REQ with imem_addr=new pc.
  - In DROP: pc is overwritten by the latest redirect. If ack arrives the same cycle, go to REQ using the new pc.
  - In IDLE: pc updated, then REQ as normal.
- Arithmetic: pc+4 and id_pc4 wrap modulo 2^32 (0xFFFF_FFFC+4 = 0x0000_0000). No overflow flag.
- imem_rdata is sampled only in REQ on an ack cycle; it is ignored in all other cycles.

Test Plan:
- Reset with RESET_PC=0, memory acks with 0 wait, id_ready=1 always -> imem_addr sequence 0x0,0x4,0x8. id_valid pulses every 2nd cycle with id_pc=0x0,0x4,0x8 and id_pc4=0x4,0x8,0xC.
- Ack for 0x0 with rdata=0x8C010004 while id_ready=0 for 5 cycles -> id_valid held 1 and id_instr stable. No imem_req asserted until the ready cycle; next request is to 0x4.
- Redirect to 0x00400103 while the request to 0x8 waits 3 cycles -> imem_addr stays 0x8 until ack. That data is never presented (id_valid stays 0). Next request is to 0x00400100, and pc=0x00400100.
- Redirect to 0x100 in the same cycle as ack for 0x4 -> rdata dropped, next imem_addr=0x100. Also redirect while in WAIT_ID with id_ready=1 -> id_valid falls and the held instruction is not counted as accepted.
- Redirect to 0xFFFFFFFC, ack -> id_pc=0xFFFFFFFC, id_pc4=0x0, next imem_addr=0x0.
- Assert rst during DROP with ack arriving the same cycle -> the next cycle has imem_req=0, id_valid=0, pc=RESET_PC. After that, the first request is to RESET_PC.
